// File: rtl/mem_access_sequencer.sv
// Multicycle byte/half/word load-store engine in front of a single-port data memory.
// Optional build macro ALIGN_CHECK_EN enables alignment-fault detection.
module mem_access_sequencer #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        op_store,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic        busy,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // Handshake: req is sampled only while busy=0 (IDLE); the fields ride with it on that
    // edge. busy stays high until the DONE cycle ends; ack pulses exactly once per accept.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [1:0]     size_q;
    logic           store_q;
    logic [15:0]    wdata_q;
    logic           align_fault;

    assign dbg_state = state;

`ifdef ALIGN_CHECK_EN
    assign align_fault = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^addr[1:0];
    assign align_fault = 1'b0;
`endif

    // Register byte i lives in memory lane i counted from the MSB.
    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [31:0] format_load(input logic [1:0] sz, input logic [31:0] m);
        case (sz)
            2'b00:   return {24'h0, m[31:24]};
            2'b01:   return {16'h0, m[23:16], m[31:24]};
            default: return bswap(m);
        endcase
    endfunction

    // Only byte and half stores reach the merge; word stores bypass the read.
    function automatic logic [31:0] merge_store(input logic [1:0] sz, input logic [15:0] w,
                                                input logic [31:0] m);
        if (sz == 2'b00)
            return {w[7:0], m[23:0]};
        return {w[7:0], w[15:8], m[15:0]};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            size_q     <= 2'b00;
            store_q    <= 1'b0;
            wdata_q    <= '0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            rdata      <= '0;
            misaligned <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack        <= 1'b0;
                    misaligned <= 1'b0;
                    if (req) begin
                        size_q   <= size;
                        store_q  <= op_store;
                        wdata_q  <= wdata[15:0];
                        mem_addr <= {addr[31:2], 2'b00};
                        busy     <= 1'b1;
                        if (align_fault) begin
                            state      <= DONE;
                            ack        <= 1'b1;
                            misaligned <= 1'b1;
                        end else if (op_store && size[1]) begin
                            state     <= WR;
                            mem_we    <= 1'b1;
                            mem_wdata <= bswap(wdata);
                        end else begin
                            state <= RD;
                            cnt   <= CW'(MEM_LAT - 1);
                        end
                    end
                end
                RD: begin
                    if (cnt == '0) begin
                        if (store_q) begin
                            state     <= WR;
                            mem_we    <= 1'b1;
                            mem_wdata <= merge_store(size_q, wdata_q, mem_rdata);
                        end else begin
                            state <= DONE;
                            ack   <= 1'b1;
                            rdata <= format_load(size_q, mem_rdata);
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WR: begin
                    state  <= DONE;
                    mem_we <= 1'b0;
                    ack    <= 1'b1;
                end
                DONE: begin
                    state      <= IDLE;
                    ack        <= 1'b0;
                    misaligned <= 1'b0;
                    busy       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: byte-lane reference model over a word memory.
// Honours ALIGN_CHECK_EN the same way as the design build.
module tb_mem_access_sequencer;

    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        op_store = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ack, busy, misaligned, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  dbg_state_unused;

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic [31:0] rd_dly [MEM_LAT-1];
    logic        load_mem = 1'b0;
    logic [31:0] model_rdata = '0;
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    mem_access_sequencer #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .op_store(op_store), .size(size),
        .addr(addr), .wdata(wdata), .ack(ack), .busy(busy), .rdata(rdata),
        .misaligned(misaligned), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state_unused)
    );

    // Clock / memory with MEM_LAT-cycle read latency
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
        end else if (mem_we) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
        rd_dly[0] <= mem[mem_addr[5:2]];
        for (int i = 1; i < MEM_LAT - 1; i++) rd_dly[i] <= rd_dly[i-1];
    end
    assign mem_rdata = rd_dly[MEM_LAT-2];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One transaction through the reference model; returns what the DUT showed.
    task automatic do_access(input logic st, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input bit noise,
                             output logic [31:0] got_rdata, output logic [31:0] got_wdata,
                             output int got_lat);
        int          idx, n, lat_exp, k, we_cycles;
        bit          fault, seen_ack, busy_bad;
        logic [31:0] m, exp_w, exp_r, exp_addr;
        idx = int'(a[5:2]);
        m = ref_mem[idx];
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
`ifdef ALIGN_CHECK_EN
        fault = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`else
        fault = 1'b0;
`endif
        exp_w = m;
        for (int i = 0; i < n; i++) exp_w[8*(3-i) +: 8] = wd[8*i +: 8];
        if (!st && !fault) begin
            exp_r = '0;
            for (int i = 0; i < n; i++) exp_r[8*i +: 8] = m[8*(3-i) +: 8];
            model_rdata = exp_r;
        end
        exp_q.push_back(model_rdata);
        if (st && !fault) ref_mem[idx] = exp_w;
        lat_exp = fault ? 1 : (st && n == 4) ? 2 : st ? MEM_LAT + 2 : MEM_LAT + 1;
        exp_addr = {a[31:2], 2'b00};

        req = 1'b1; op_store = st; size = sz; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0;
        k = 0; seen_ack = 0; we_cycles = 0; busy_bad = 0;
        got_rdata = '0; got_wdata = '0;
        while (!seen_ack && k < 20) begin
            @(negedge clk);
            k++;
            if (mem_we) begin
                we_cycles++;
                got_wdata = mem_wdata;
            end
            if (!busy) busy_bad = 1;
            if (ack) begin
                seen_ack = 1;
                got_rdata = rdata;
                checks++;
                if (misaligned !== fault) begin
                    errors++;
                    $display("FAIL misaligned: got %b expected %b (addr %h size %0d)", misaligned, fault, a, sz);
                end
                checks++;
                if (rdata !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rdata: got %h expected %h (addr %h size %0d store %b)", rdata, exp_q[0], a, sz, st);
                end
                checks++;
                if (mem_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL mem_addr: got %h expected %h", mem_addr, exp_addr);
                end
            end
            if (noise && k == 1) begin
                req = 1'b1; op_store = 1'($urandom_range(0, 1)); size = 2'($urandom_range(0, 3));
                addr = 32'($urandom_range(0, 63)); wdata = $urandom;
            end else begin
                req = 1'b0;
            end
        end
        void'(exp_q.pop_front());
        got_lat = k;
        checks++;
        if (!seen_ack || k != lat_exp) begin
            errors++;
            $display("FAIL latency: got %0d (ack seen %b) expected %0d (addr %h size %0d store %b)", k, seen_ack, lat_exp, a, sz, st);
        end
        checks++;
        if (we_cycles != ((st && !fault) ? 1 : 0)) begin
            errors++;
            $display("FAIL mem_we_cycles: got %0d expected %0d", we_cycles, (st && !fault) ? 1 : 0);
        end
        if (st && !fault) begin
            checks++;
            if (got_wdata !== exp_w) begin
                errors++;
                $display("FAIL mem_wdata: got %h expected %h (addr %h size %0d)", got_wdata, exp_w, a, sz);
            end
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL busy_during_access: got 0 expected 1");
        end
        req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL return_idle: got busy %b ack %b expected 0 0", busy, ack);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({ack, busy, misaligned, mem_we} !== 4'b0000 || rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL %s: got ack %b busy %b mis %b we %b rdata %h addr %h wdata %h expected all zero",
                     tag, ack, busy, misaligned, mem_we, rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        ref_mem[4] = 32'h1122_3344;
        #2 reset = 1'b0;
        load_mem = 1'b1;
        @(posedge clk); #1;
        load_mem = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_directed_loads();
        logic [31:0] r, w;
        int          lat;
        do_access(1'b0, 2'b10, 32'h10, '0, 1'b0, r, w, lat);
        checks++;
        if (r !== 32'h4433_2211 || lat != MEM_LAT + 1) begin
            errors++;
            $display("FAIL load_word_direct: got %h lat %0d expected 44332211 lat %0d", r, lat, MEM_LAT + 1);
        end
        do_access(1'b0, 2'b01, 32'h10, '0, 1'b0, r, w, lat);
        checks++;
        if (r !== 32'h0000_2211) begin
            errors++;
            $display("FAIL load_half_direct: got %h expected 00002211", r);
        end
        do_access(1'b0, 2'b00, 32'h10, '0, 1'b0, r, w, lat);
        checks++;
        if (r !== 32'h0000_0011) begin
            errors++;
            $display("FAIL load_byte_direct: got %h expected 00000011", r);
        end
    endtask

    task automatic test_align();
        logic [31:0] r, w;
        int          lat;
        do_access(1'b0, 2'b10, 32'h12, '0, 1'b0, r, w, lat);
        checks++;
`ifdef ALIGN_CHECK_EN
        if (r !== 32'h0000_0011 || lat != 1) begin
            errors++;
            $display("FAIL align_fault_word: got %h lat %0d expected 00000011 lat 1", r, lat);
        end
`else
        if (r !== 32'h4433_2211) begin
            errors++;
            $display("FAIL align_ignored_word: got %h expected 44332211", r);
        end
`endif
    endtask

    task automatic test_directed_stores();
        logic [31:0] r, w;
        int          lat;
        do_access(1'b1, 2'b00, 32'h10, 32'hAABB_CCDD, 1'b0, r, w, lat);
        checks++;
        if (w !== 32'hDD22_3344 || lat != MEM_LAT + 2) begin
            errors++;
            $display("FAIL store_byte_direct: got %h lat %0d expected DD223344 lat %0d", w, lat, MEM_LAT + 2);
        end
        do_access(1'b1, 2'b01, 32'h10, 32'hAABB_CCDD, 1'b1, r, w, lat);
        checks++;
        if (w !== 32'hDDCC_3344) begin
            errors++;
            $display("FAIL store_half_direct: got %h expected DDCC3344", w);
        end
        do_access(1'b1, 2'b10, 32'h10, 32'hAABB_CCDD, 1'b1, r, w, lat);
        checks++;
        if (w !== 32'hDDCC_BBAA || lat != 2) begin
            errors++;
            $display("FAIL store_word_direct: got %h lat %0d expected DDCCBBAA lat 2", w, lat);
        end
    endtask

    // req held high through DONE must only be taken on the following IDLE cycle.
    task automatic test_back_to_back();
        logic [31:0] wd1, wd2;
        bit          ok;
        wd1 = $urandom; wd2 = $urandom;
        ref_mem[0] = {wd1[7:0], wd1[15:8], wd1[23:16], wd1[31:24]};
        ref_mem[1] = {wd2[7:0], wd2[15:8], wd2[23:16], wd2[31:24]};
        req = 1'b1; op_store = 1'b1; size = 2'b10; addr = 32'h0; wdata = wd1;
        @(posedge clk); #1;
        addr = 32'h4; wdata = wd2;
        ok = 1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1 && !(mem_we && mem_wdata === ref_mem[0])) ok = 0;
            if (k == 2 && ack !== 1'b1) ok = 0;
            if (k == 3 && (busy !== 1'b0 || ack !== 1'b0)) ok = 0;
            if (k == 4) begin
                if (!(mem_we && mem_wdata === ref_mem[1] && mem_addr === 32'h4)) ok = 0;
                req = 1'b0;
            end
            if (k == 5 && ack !== 1'b1) ok = 0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL back_to_back: got sequence error (busy %b ack %b) expected done-cycle req deferred", busy, ack);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        logic [31:0] r, w;
        int          lat, k;
        req = 1'b1; op_store = 1'b1; size = 2'b00; addr = 32'h24; wdata = $urandom;
        @(posedge clk); #1;
        req = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!mem_we && k < 10);
        checks++;
        if (!mem_we) begin
            errors++;
            $display("FAIL abort_reach_wr: got mem_we 0 expected 1");
        end
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_during_wr");
        @(posedge clk); @(posedge clk); @(negedge clk);
        reset = 1'b1;
        model_rdata = '0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack || busy) k++;
        end
        checks++;
        if (k != 0) begin
            errors++;
            $display("FAIL abort_no_ack: got %0d active cycles expected 0", k);
        end
        checks++;
        if (mem[9] !== ref_mem[9]) begin
            errors++;
            $display("FAIL abort_no_write: got %h expected %h", mem[9], ref_mem[9]);
        end
        do_access(1'b0, 2'b10, 32'h24, '0, 1'b0, r, w, lat);
    endtask

    task automatic test_random();
        logic [31:0] r, w;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)),
                      $urandom, 1'($urandom_range(0, 1)), r, w, lat);
        end
    endtask

    task automatic test_mem_final();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[i] !== ref_mem[i]) begin
                errors++;
                $display("FAIL mem_word_%0d: got %h expected %h", i, mem[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed_loads();
        test_align();
        test_directed_stores();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_mem_final();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Multicycle load/store engine between the CPU control unit and the single-port data memory. Accepts one byte/half/word request at a time and performs the memory transactions. Sub-word stores use read-modify-write. Applies the CPU's byte-lane convention: the register value is the byte-reverse of the memory word, so register byte 0 maps to mem[31:24].

Parameters:
MEM_LAT, 1, memory read latency in cycles (>=1); mem_rdata is valid MEM_LAT cycles after mem_addr is presented.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
req  in  1  request strobe; sampled only in IDLE.
op_store  in  1  1 = store, 0 = load.
size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
addr  in  32  byte address of the access.
wdata  in  32  store data (register B).
ack  out  1  one-cycle completion pulse.
busy  out  1  high in every non-IDLE state.
rdata  out  32  formatted load result; held until the next load completes.
misaligned  out  1  alignment fault pulse, coincident with ack.
mem_addr  out  32  {addr_q[31:2],2'b00}.
mem_we  out  1  memory write enable.
mem_wdata  out  32  memory write data.
mem_rdata  in  32  memory read data.

Behaviour:
- Reset (async, reset=0): state IDLE. ack=0, busy=0, rdata=0, misaligned=0, mem_addr=0, mem_we=0, mem_wdata=0. Any in-flight access is aborted: no write, no ack.
- Request capture:
  - In IDLE with req=1, register addr, size, op_store and wdata.
  - Word store (size 10 or 11) goes to WR; everything else goes to RD.
  - req is ignored while busy=1.
- RD: mem_addr driven, mem_we=0, down-counter loaded with MEM_LAT-1.
  - Stay until the counter reaches 0; on that cycle capture mem_rdata into word_q.
  - Then load goes to DONE; sub-word store goes to WR.
- Load formatting (on entry to DONE), with m = word_q:
  - word: rdata = {m[7:0],m[15:8],m[23:16],m[31:24]}
  - half: rdata = {16'h0,m[23:16],m[31:24]}
  - byte: rdata = {24'h0,m[31:24]}
  - Zero-extend only.
- WR: exactly one cycle, mem_we=1, then DONE. mem_wdata:
  - byte store: {wdata[7:0],m[23:0]}
  - half store: {wdata[7:0],wdata[15:8],m[15:0]}
  - word store: {wdata[7:0],wdata[15:8],wdata[23:16],wdata[31:24]}
- DONE: ack=1 for one cycle, then IDLE. A req present in this cycle is not accepted; it is accepted next cycle in IDLE.
- Latency (req-accept edge to ack cycle):
  - load: MEM_LAT+1 cycles
  - sub-word store: MEM_LAT+2 cycles
  - word store: 2 cycles
- mem_we is registered and high only in WR. mem_addr stays stable from RD entry through DONE.
- addr[1:0] is ignored for data placement; accesses are always to the lowest lanes of the aligned word.

Optional Feature:
ALIGN_CHECK_EN
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, skips RD/WR and goes IDLE -> DONE.
  - ack=1 and misaligned=1 in that cycle. mem_we stays 0 and rdata is unchanged.
- Undefined: misaligned is tied to 0 and the low address bits are ignored.

Test Plan:
- MEM_LAT=1, memory[0x10]=0x11223344, load word addr 0x10 -> ack 2 cycles after accept, rdata=0x44332211, mem_we never high.
- Same word, load half, then load byte -> rdata=0x00002211, then rdata=0x00000011.
- MEM_LAT=2, byte store wdata=0xAABBCCDD to 0x10 -> one WR cycle with mem_wdata=0xDD223344, ack 4 cycles after accept.
- Half store, same data -> mem_wdata=0xDDCC3344. Word store -> no RD, mem_wdata=0xDDCCBBAA, ack 2 cycles after accept. req pulsed while busy is ignored.
- reset driven low during WR of a byte store -> mem_we drops immediately, no ack, busy=0, outputs at reset values. A next request completes normally.
- ALIGN_CHECK_EN defined, load word addr 0x12 -> ack+misaligned 1 cycle after accept, no memory access. Undefined -> rdata=0x44332211, misaligned=0.
